wb_copy_master: RTL and testbench
=================================

# wb_copy_master

Wishbone pipelined-mode bus master that copies a block of 32-bit words from a source address to a destination address, one word at a time (read, then write). It is the initiator counterpart to the slaves on the core's data bus. It drives the same cyc/stb/we/adr/dat/sel signal set the core's data port presents to the address-decoding interconnect, and consumes stall/ack/err/dat from whichever slave is selected. Software or a loader FSM starts it through a simple start/len control interface.

## Interface
- LEN_WIDTH, 16: width of the word-count input.
- ACK_TIMEOUT, 255: cycles to wait for ack/err after a strobe is accepted before aborting; 0 disables the timeout.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start pulse; sampled only in IDLE.
- src_adr_i  in  32  first source byte address, word-aligned; captured on start.
- dst_adr_i  in  32  first destination byte address, word-aligned; captured on start.
- len_i  in  LEN_WIDTH  number of words to copy; captured on start.
- busy_o  out  1  high from the cycle after an accepted start until the return to IDLE.
- done_o  out  1  one-cycle pulse when the copy ends (success or abort).
- err_o  out  1  sticky abort flag; cleared by the next accepted start.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master control.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects; always 4'hF while stb is high, 4'h0 otherwise.
- wb_stall_i, wb_ack_i, wb_err_i  in  1 each  slave response.
- wb_dat_i  in  32  read data.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE, start_i=1:
  - Latch src, dst, len; clear err_o.
  - If len=0, go to FINISH with no bus activity.
  - Otherwise go to RD_REQ.
- RD_REQ:
  - Drive cyc=1, stb=1, we=0, adr=src.
  - Hold stb and adr stable while wb_stall_i=1.
  - When stall=0, the strobe is accepted. Go to RD_WAIT, or directly to WR_REQ if ack is already present in the same cycle (data latched).
- RD_WAIT:
  - stb=0, cyc=1.
  - On ack: latch wb_dat_i into the data register and go to WR_REQ.
- WR_REQ:
  - Drive stb=1, we=1, adr=dst, dat=the latched word.
  - Stall handling is the same as RD_REQ.
- WR_WAIT:
  - On ack: src+=4, dst+=4, remaining-=1.
  - If remaining becomes 0, go to FINISH; else go to RD_REQ.
- Address arithmetic: 32-bit increments wrap modulo 2^32 without any flag.
- Error, in any REQ or WAIT state:
  - wb_err_i=1 → set err_o, drop cyc/stb next edge, go to FINISH.
  - err takes priority over a simultaneous ack.
- Timeout:
  - A counter is cleared when a strobe is accepted and increments each WAIT cycle without ack/err.
  - When it reaches ACK_TIMEOUT (and ACK_TIMEOUT≠0): set err_o and go to FINISH.
- FINISH: cyc=0, done_o=1 for this cycle, busy_o=0; then go to IDLE.
- cyc stays high continuously from the first RD_REQ to leaving the last WAIT state, including between words.
- start_i while not in IDLE is ignored; inputs are not re-sampled.
- Responses arriving while cyc=0 (stale ack) are ignored.

## Timing
- Reset: state=IDLE.
  - All outputs 0: cyc, stb, we, adr, dat, sel, busy, done, err.
  - Counters cleared.
- Reset asserted mid-transfer forces the reset values at the next edge. No done pulse is produced.
- Latency, zero-wait slave (stall=0, ack one cycle after acceptance):
  - start edge → RD_REQ on the next cycle.
  - 4 cycles per word.
  - done_o asserted in the cycle after the last write ack.
  - An N-word copy takes 4N+2 cycles from start to done inclusive.
- Same-cycle ack (combinational slave) shortens a word to 2 cycles.
- Each stall cycle adds exactly one cycle. adr, we, dat and sel are held constant during stall.
- All outputs are registered; no combinational path from wb_* inputs to wb_* outputs.

## Structure
- Shared package wb_pkg:
  - State encoding constants.
  - WB_SEL_WORD=4'hF.
  - WB_WORD_BYTES=4.
  - Other masters reuse it.
- One sub-module: wb_ack_timer (parameter ACK_TIMEOUT).
  - Inputs: clear, count-enable.
  - Output: expired pulse.
- Everything else stays in the single FSM module.

## Test plan
- len=3, src=0x0000_0100, dst=0x0000_0200, zero-wait memory model:
  - 3 reads then 3 writes at 0x100/0x200, 0x104/0x204, 0x108/0x208.
  - Destination matches source.
  - done_o pulses at cycle 14 after start.
  - err_o=0.
- len=0:
  - done_o pulses on the second cycle after start.
  - cyc never asserted; busy_o never asserted beyond FINISH.
- Slave stalls the first write for 3 cycles:
  - adr=dst, dat and we held constant during the 3 stall cycles.
  - Total copy time +3 cycles.
- Slave returns err on the second read of len=4:
  - err_o=1, done_o pulse, cyc drops.
  - Only 1 destination word written.
  - A new start clears err_o.
- ACK_TIMEOUT=8, slave never acks:
  - err_o set and done pulses 8 cycles after strobe acceptance.
- Reset asserted during WR_WAIT:
  - All outputs 0 at the next edge, no done pulse.
  - A subsequent start copies correctly.
- src=0xFFFF_FFFC, len=2:
  - Second read address is 0x0000_0000 (wrap).

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone master definitions: bus widths, select constants, state encoding
// and the registered master-to-slave payload used by the copy engine and its siblings.
package wb_pkg;

    localparam int unsigned WB_ADR_WIDTH  = 32;
    localparam int unsigned WB_DAT_WIDTH  = 32;
    localparam int unsigned WB_SEL_WIDTH  = WB_DAT_WIDTH / 8;
    localparam int unsigned WB_WORD_BYTES = 4;

    localparam logic [WB_SEL_WIDTH-1:0] WB_SEL_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } wb_master_state_e;

    typedef struct packed {
        logic                    cyc;
        logic                    stb;
        logic                    we;
        logic [WB_ADR_WIDTH-1:0] adr;
        logic [WB_DAT_WIDTH-1:0] dat;
        logic [WB_SEL_WIDTH-1:0] sel;
    } wb_m2s_t;

    // Next word address; wraps silently modulo 2^32.
    function automatic logic [WB_ADR_WIDTH-1:0] wb_next_word(input logic [WB_ADR_WIDTH-1:0] adr);
        return adr + WB_ADR_WIDTH'(WB_WORD_BYTES);
    endfunction

    function automatic logic wb_state_has_cyc(input wb_master_state_e s);
        return (s == ST_RD_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_REQ) || (s == ST_WR_WAIT);
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Ack watchdog: counts response-wait cycles after a strobe is accepted and flags
// expiry on the ACK_TIMEOUT-th consecutive idle wait cycle (ACK_TIMEOUT=0 disables it).
module wb_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic count_en,
    output logic expired_c
);

    localparam int unsigned CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned LIMIT   = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam bit          ENABLED = (ACK_TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires during the wait cycle whose increment would reach ACK_TIMEOUT.
    assign expired_c = ENABLED && count_en && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone pipelined block-copy master: reads one word from src, writes it to dst,
// repeats len times; aborts on bus error or ack timeout.
module wb_copy_master
    import wb_pkg::*;
#(
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start_i,
    input  logic [WB_ADR_WIDTH-1:0] src_adr_i,
    input  logic [WB_ADR_WIDTH-1:0] dst_adr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
    output logic [WB_SEL_WIDTH-1:0] wb_sel_o,
    input  logic                    wb_stall_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic [WB_DAT_WIDTH-1:0] wb_dat_i
);

    wb_master_state_e        state_q, state_d;
    logic [WB_ADR_WIDTH-1:0] src_q, src_d;
    logic [WB_ADR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [WB_DAT_WIDTH-1:0] data_q, data_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    wb_m2s_t                 bus_q, bus_d;

    logic                    accept_c;
    logic                    word_done_c;
    logic                    abort_c;
    logic                    wait_idle_c;
    logic                    expired_c;

    // Only count wait cycles that brought no response at all.
    assign wait_idle_c = ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) && !wb_ack_i && !wb_err_i;

    wb_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clear     (accept_c),
        .count_en  (wait_idle_c),
        .expired_c (expired_c)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        data_d      = data_q;
        err_d       = err_q;
        accept_c    = 1'b0;
        word_done_c = 1'b0;
        abort_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = src_adr_i;
                    dst_d   = dst_adr_i;
                    rem_d   = len_i;
                    err_d   = 1'b0;
                    state_d = (len_i == '0) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (wb_err_i) begin
                    abort_c = 1'b1;
                end else if (!wb_stall_i) begin
                    accept_c = 1'b1;
                    if (wb_ack_i) begin
                        data_d  = wb_dat_i;
                        state_d = ST_WR_REQ;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (wb_err_i) begin
                    abort_c = 1'b1;
                end else if (wb_ack_i) begin
                    data_d  = wb_dat_i;
                    state_d = ST_WR_REQ;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (wb_err_i) begin
                    abort_c = 1'b1;
                end else if (!wb_stall_i) begin
                    accept_c = 1'b1;
                    if (wb_ack_i) begin
                        word_done_c = 1'b1;
                    end else begin
                        state_d = ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (wb_err_i) begin
                    abort_c = 1'b1;
                end else if (wb_ack_i) begin
                    word_done_c = 1'b1;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (word_done_c) begin
            src_d   = wb_next_word(src_q);
            dst_d   = wb_next_word(dst_q);
            rem_d   = rem_q - LEN_WIDTH'(1);
            state_d = (rem_q == LEN_WIDTH'(1)) ? ST_FINISH : ST_RD_REQ;
        end

        if (abort_c) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
        end
    end

    // Bus outputs are decoded from the next state so they leave a flop, never a wb_* input.
    always_comb begin
        bus_d     = bus_q;
        bus_d.cyc = wb_state_has_cyc(state_d);
        bus_d.stb = 1'b0;
        bus_d.we  = 1'b0;
        bus_d.sel = '0;

        unique case (state_d)
            ST_RD_REQ: begin
                bus_d.stb = 1'b1;
                bus_d.adr = src_d;
                bus_d.sel = WB_SEL_WORD;
            end
            ST_WR_REQ: begin
                bus_d.stb = 1'b1;
                bus_d.we  = 1'b1;
                bus_d.adr = dst_d;
                bus_d.dat = data_d;
                bus_d.sel = WB_SEL_WORD;
            end
            default: begin
            end
        endcase

        busy_d = bus_d.cyc;
        done_d = (state_d == ST_FINISH);
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign wb_cyc_o = bus_q.cyc;
    assign wb_stb_o = bus_q.stb;
    assign wb_we_o  = bus_q.we;
    assign wb_adr_o = bus_q.adr;
    assign wb_dat_o = bus_q.dat;
    assign wb_sel_o = bus_q.sel;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: memory-backed slave model, scoreboard of expected bus
// transactions, and latency/status checks per copy.
module tb_wb_copy_master;

    typedef struct {
        bit        we;
        bit [31:0] adr;
        bit [31:0] dat;
    } txn_t;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        start_i;
    logic [31:0] src_adr_i;
    logic [31:0] dst_adr_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    wb_copy_master #(
        .LEN_WIDTH   (16),
        .ACK_TIMEOUT (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start_i    (start_i),
        .src_adr_i  (src_adr_i),
        .dst_adr_i  (dst_adr_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit [31:0] mem [bit [31:0]];
    txn_t      sb_q [$];

    // Slave model configuration and state.
    bit        same_cycle   = 1'b0;
    bit        no_ack       = 1'b0;
    int        stall_left   = 0;
    int        err_read_idx = -1;
    int        rd_count     = 0;
    int        writes_seen  = 0;
    bit        pend_valid   = 1'b0;
    bit        pend_err     = 1'b0;
    bit [31:0] pend_rdata   = '0;
    bit        cyc_seen     = 1'b0;
    bit        busy_seen    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_slave(input bit sc, input bit na, input int stalls, input int err_idx);
        same_cycle   = sc;
        no_ack       = na;
        stall_left   = stalls;
        err_read_idx = err_idx;
        rd_count     = 0;
        writes_seen  = 0;
    endtask

    // Slave + monitor: sample DUT outputs at negedge, then drive responses for the next posedge.
    always @(negedge wb_clk_i) begin
        txn_t exp_t;
        bit   is_err;
        if (wb_rst_i) begin
            pend_valid = 1'b0;
            wb_ack_i   = 1'b0;
            wb_err_i   = 1'b0;
            wb_stall_i = 1'b0;
        end else begin
            cyc_seen  = cyc_seen | wb_cyc_o;
            busy_seen = busy_seen | busy_o;
            wb_ack_i  = 1'b0;
            wb_err_i  = 1'b0;
            if (pend_valid) begin
                if (pend_err) begin
                    wb_err_i = 1'b1;
                end else if (!no_ack) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = pend_rdata;
                end
            end
            pend_valid = 1'b0;
            wb_stall_i = 1'b0;
            if (wb_cyc_o && wb_stb_o && wb_we_o && stall_left > 0) begin
                wb_stall_i = 1'b1;
                stall_left--;
                if (sb_q.size() > 0) begin
                    exp_t = sb_q[0];
                    check_eq("stall_adr", wb_adr_o, exp_t.adr);
                    check_eq("stall_dat", wb_dat_o, exp_t.dat);
                    check_eq("stall_we", 32'(wb_we_o), 32'(exp_t.we));
                end
            end
            if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
                check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_t = sb_q.pop_front();
                    check_eq("bus_we", 32'(wb_we_o), 32'(exp_t.we));
                    check_eq("bus_adr", wb_adr_o, exp_t.adr);
                    check_eq("bus_sel", 32'(wb_sel_o), 32'h0000_000F);
                    if (exp_t.we) begin
                        check_eq("bus_wdat", wb_dat_o, exp_t.dat);
                    end
                end
                is_err = 1'b0;
                if (wb_we_o) begin
                    mem[wb_adr_o] = wb_dat_o;
                    writes_seen++;
                end else begin
                    is_err = (rd_count == err_read_idx);
                    rd_count++;
                end
                if (same_cycle && !is_err && !no_ack) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = mem[wb_adr_o];
                end else begin
                    pend_valid = 1'b1;
                    pend_err   = is_err;
                    pend_rdata = mem[wb_adr_o];
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_cyc"},  32'(wb_cyc_o), 32'd0);
        check_eq({tag, "_stb"},  32'(wb_stb_o), 32'd0);
        check_eq({tag, "_we"},   32'(wb_we_o),  32'd0);
        check_eq({tag, "_adr"},  wb_adr_o,      32'd0);
        check_eq({tag, "_dat"},  wb_dat_o,      32'd0);
        check_eq({tag, "_sel"},  32'(wb_sel_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o),   32'd0);
        check_eq({tag, "_done"}, 32'(done_o),   32'd0);
        check_eq({tag, "_err"},  32'(err_o),    32'd0);
    endtask

    // Seeds source words and pushes the expected read/write sequence.
    task automatic load_copy(input bit [31:0] src, input bit [31:0] dst, input int len,
                             output bit [31:0] vals [$]);
        bit [31:0] a;
        vals.delete();
        sb_q.delete();
        for (int i = 0; i < len; i++) begin
            a      = src + 32'(4 * i);
            mem[a] = $urandom;
            vals.push_back(mem[a]);
        end
        for (int i = 0; i < len; i++) begin
            sb_q.push_back('{we: 1'b0, adr: src + 32'(4 * i), dat: 32'd0});
            sb_q.push_back('{we: 1'b1, adr: dst + 32'(4 * i), dat: vals[i]});
        end
    endtask

    task automatic pulse_start(input bit [31:0] src, input bit [31:0] dst, input int len);
        @(negedge wb_clk_i);
        start_i   = 1'b1;
        src_adr_i = src;
        dst_adr_i = dst;
        len_i     = 16'(len);
        @(negedge wb_clk_i);
        start_i   = 1'b0;
        src_adr_i = 32'hDEAD_BEEF;
        dst_adr_i = 32'hDEAD_BEEF;
        len_i     = 16'd7;
    endtask

    task automatic run_copy(input string tag, input bit [31:0] src, input bit [31:0] dst,
                            input int len, input int exp_cycles, input bit exp_err,
                            input int exp_writes);
        bit [31:0] vals [$];
        int        n;
        load_copy(src, dst, len, vals);
        cyc_seen  = 1'b0;
        busy_seen = 1'b0;
        pulse_start(src, dst, len);
        n = 1;
        check_eq({tag, "_err_clear"}, 32'(err_o), 32'd0);
        check_eq({tag, "_busy_early"}, 32'(busy_o), 32'(len != 0));
        while (!done_o && n < 400) begin
            @(negedge wb_clk_i);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_o), 32'd1);
        check_eq({tag, "_latency"}, 32'(n + 1), 32'(exp_cycles));
        check_eq({tag, "_err"}, 32'(err_o), 32'(exp_err));
        check_eq({tag, "_cyc_at_done"}, 32'(wb_cyc_o), 32'd0);
        check_eq({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_writes"}, 32'(writes_seen), 32'(exp_writes));
        for (int i = 0; i < exp_writes; i++) begin
            check_eq({tag, "_dst_word"}, mem[dst + 32'(4 * i)], vals[i]);
        end
        if (len == 0) begin
            check_eq({tag, "_no_cyc"}, 32'(cyc_seen), 32'd0);
            check_eq({tag, "_no_busy"}, 32'(busy_seen), 32'd0);
        end
        if (!exp_err) begin
            check_eq({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        end
        @(negedge wb_clk_i);
        check_eq({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        bit [31:0] vals [$];
        wb_rst_i   = 1'b1;
        start_i    = 1'b0;
        src_adr_i  = '0;
        dst_adr_i  = '0;
        len_i      = '0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_dat_i   = '0;

        repeat (3) @(negedge wb_clk_i);
        check_outputs_zero("reset");
        wb_rst_i = 1'b0;

        set_slave(1'b0, 1'b0, 0, -1);
        run_copy("zw_len3", 32'h0000_0100, 32'h0000_0200, 3, 14, 1'b0, 3);

        set_slave(1'b0, 1'b0, 0, -1);
        run_copy("len0", 32'h0000_0300, 32'h0000_0380, 0, 2, 1'b0, 0);

        set_slave(1'b1, 1'b0, 0, -1);
        run_copy("comb_len3", 32'h0000_0400, 32'h0000_0500, 3, 8, 1'b0, 3);

        set_slave(1'b0, 1'b0, 3, -1);
        run_copy("stall3", 32'h0000_0600, 32'h0000_0700, 2, 13, 1'b0, 2);

        set_slave(1'b0, 1'b0, 0, 1);
        run_copy("err_rd2", 32'h0000_0800, 32'h0000_0900, 4, 8, 1'b1, 1);

        set_slave(1'b0, 1'b0, 0, -1);
        run_copy("after_err", 32'h0000_0A00, 32'h0000_0B00, 1, 6, 1'b0, 1);

        set_slave(1'b0, 1'b1, 0, -1);
        run_copy("timeout", 32'h0000_0C00, 32'h0000_0D00, 1, 11, 1'b1, 0);

        // Reset during the first write's wait cycle.
        set_slave(1'b0, 1'b0, 0, -1);
        load_copy(32'h0000_1000, 32'h0000_1100, 2, vals);
        pulse_start(32'h0000_1000, 32'h0000_1100, 2);
        repeat (3) @(negedge wb_clk_i);
        check_eq("rst_pre_wr_wait", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check_outputs_zero("midrst");
        wb_rst_i = 1'b0;
        sb_q.delete();
        @(negedge wb_clk_i);
        check_eq("midrst_no_done", 32'(done_o), 32'd0);
        check_eq("midrst_idle_cyc", 32'(wb_cyc_o), 32'd0);

        set_slave(1'b0, 1'b0, 0, -1);
        run_copy("post_rst", 32'h0000_0E00, 32'h0000_0F00, 2, 10, 1'b0, 2);

        set_slave(1'b0, 1'b0, 0, -1);
        run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_3000, 2, 10, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
